// File: rtl/bsg_vanilla_instr_encoder_if.sv
// Bundles the descriptor handshake (valid/ready) and the instruction output
// handshake (valid/yumi) of the vanilla instruction encoder.
interface bsg_vanilla_instr_encoder_if;
    // descriptor side
    logic        v_i;
    logic        ready_o;
    logic [2:0]  kind_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;

    // instruction side
    logic        v_o;
    logic [31:0] instr_o;
    logic        err_o;
    logic        yumi_i;
    logic [15:0] count_o;

    // the encoder itself
    modport slave (
        input  v_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, yumi_i,
        output ready_o, v_o, instr_o, err_o, count_o
    );

    // the producer/consumer driving the encoder
    modport master (
        output v_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, yumi_i,
        input  ready_o, v_o, instr_o, err_o, count_o
    );
endinterface

// File: rtl/bsg_vanilla_instr_encoder.sv
// RV32 instruction encoder: turns decoded descriptors into instruction words.
// A 32-bit load-immediate that needs both halves becomes LUI followed by ADDI.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// e_idle   | accepting descriptors whenever the output slot is free
// e_second | LUI of a two-word LI is in the slot; ADDI waits in second_r
module bsg_vanilla_instr_encoder (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    bsg_vanilla_instr_encoder_if.slave        bus
);

    localparam logic [2:0] kind_op     = 3'd0;
    localparam logic [2:0] kind_op_imm = 3'd1;
    localparam logic [2:0] kind_load   = 3'd2;
    localparam logic [2:0] kind_store  = 3'd3;
    localparam logic [2:0] kind_branch = 3'd4;
    localparam logic [2:0] kind_li     = 3'd5;
    localparam logic [2:0] kind_op_fp  = 3'd6;

    localparam logic [6:0] opc_op     = 7'b0110011;
    localparam logic [6:0] opc_op_imm = 7'b0010011;
    localparam logic [6:0] opc_load   = 7'b0000011;
    localparam logic [6:0] opc_store  = 7'b0100011;
    localparam logic [6:0] opc_branch = 7'b1100011;
    localparam logic [6:0] opc_lui    = 7'b0110111;
    localparam logic [6:0] opc_op_fp  = 7'b1010011;

    typedef enum logic {
        e_idle,
        e_second
    } state_e;

    state_e      state_r;
    logic        v_r;
    logic [31:0] instr_r;
    logic        err_r;
    logic [31:0] second_r;
    logic [15:0] count_r;

    logic [31:0] imm;
    logic        imm12_ok;
    logic        shamt_ok;
    logic        branch_ok;
    logic        is_shift;
    logic [19:0] li_hi;
    logic [11:0] li_lo;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        enc_two;
    logic [31:0] enc_second;

    logic        slot_free;
    logic        accept;
    logic        yumi;

    assign imm = bus.imm_i;

    // Range checks expressed as sign-extension tests: the value fits when all
    // bits above the field agree with its top bit.
    assign imm12_ok  = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign shamt_ok  = (imm[31:5] == '0);
    assign branch_ok = !imm[0] && ((imm[31:12] == '0) || (imm[31:12] == '1));
    assign is_shift  = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b101);

    // (imm + 0x800) >> 12: the low 12-bit add carries out exactly when imm[11]=1,
    // which pre-compensates the sign extension ADDI applies to lo.
    assign li_hi = imm[31:12] + {19'd0, imm[11]};
    assign li_lo = imm[11:0];

    assign yumi      = bus.yumi_i;
    assign slot_free = !v_r || yumi;
    assign accept    = bus.v_i && bus.ready_o;

    assign bus.ready_o = (state_r == e_idle) && slot_free;
    assign bus.v_o     = v_r;
    assign bus.instr_o = instr_r;
    assign bus.err_o   = err_r;
    assign bus.count_o = count_r;

    // Encode the presented descriptor into the first (and possibly second) word.
    always_comb begin
        enc_word   = '0;
        enc_err    = 1'b0;
        enc_two    = 1'b0;
        enc_second = '0;
        unique case (bus.kind_i)
            kind_op: begin
                enc_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, opc_op};
            end
            kind_op_fp: begin
                enc_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, opc_op_fp};
            end
            kind_op_imm: begin
                if (is_shift) begin
                    enc_word = {bus.funct7_i, imm[4:0], bus.rs1_i, bus.funct3_i, bus.rd_i, opc_op_imm};
                    enc_err  = !shamt_ok;
                end else begin
                    enc_word = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, opc_op_imm};
                    enc_err  = !imm12_ok;
                end
            end
            kind_load: begin
                enc_word = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, opc_load};
                enc_err  = !imm12_ok;
            end
            kind_store: begin
                enc_word = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], opc_store};
                enc_err  = !imm12_ok;
            end
            kind_branch: begin
                enc_word = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                            imm[4:1], imm[11], opc_branch};
                enc_err  = !branch_ok;
            end
            kind_li: begin
                if (imm12_ok) begin
                    // ADDI rd, x0, lo
                    enc_word = {li_lo, 5'd0, 3'b000, bus.rd_i, opc_op_imm};
                end else if (li_lo == 12'd0) begin
                    enc_word = {li_hi, bus.rd_i, opc_lui};
                end else begin
                    enc_word   = {li_hi, bus.rd_i, opc_lui};
                    enc_two    = 1'b1;
                    // ADDI rd, rd, lo
                    enc_second = {li_lo, bus.rd_i, 3'b000, bus.rd_i, opc_op_imm};
                end
            end
            default: begin
                enc_word = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Sequencer and output slot: load on accept, drain on yumi, inject the ADDI half.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_idle;
            v_r      <= 1'b0;
            instr_r  <= '0;
            err_r    <= 1'b0;
            second_r <= '0;
        end else begin
            unique case (state_r)
                e_idle: begin
                    if (accept) begin
                        v_r     <= 1'b1;
                        instr_r <= enc_word;
                        err_r   <= enc_err;
                        if (enc_two) begin
                            second_r <= enc_second;
                            state_r  <= e_second;
                        end
                    end else if (slot_free) begin
                        v_r <= 1'b0;
                    end
                end
                e_second: begin
                    if (slot_free) begin
                        v_r     <= 1'b1;
                        instr_r <= second_r;
                        err_r   <= 1'b0;
                        state_r <= e_idle;
                    end
                end
                default: begin
                    state_r <= e_idle;
                end
            endcase
        end
    end

    // Count consumed words; 16-bit wrap is intentional.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (v_r && yumi) begin
            count_r <= count_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_bsg_vanilla_instr_encoder.sv
// Self-checking bench for bsg_vanilla_instr_encoder: a queue-based reference
// model checked every cycle, plus literal spot checks of known encodings.
module tb_bsg_vanilla_instr_encoder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic yumi_en;

    always #5 clk = ~clk;

    bsg_vanilla_instr_encoder_if bus ();

    // Consumer only ever takes a word that is actually valid.
    assign bus.yumi_i = yumi_en & bus.v_o;

    bsg_vanilla_instr_encoder dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    typedef struct {
        logic [31:0] w;
        logic        e;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] mcount = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(logic [31:0] w, logic e);
        exp_t x;
        x.w = w;
        x.e = e;
        q.push_back(x);
    endfunction

    // Reference encoder: what the descriptor must produce, straight from the ISA formats.
    function automatic void model_accept(logic [2:0] kind, logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                         logic [31:0] imm);
        int          s;
        logic [31:0] sum;
        logic [19:0] hi;
        logic [11:0] lo;
        bit          in12;
        s    = $signed(imm);
        in12 = (s >= -2048) && (s <= 2047);
        case (kind)
            3'd0: push({f7, rs2, rs1, f3, rd, 7'h33}, 1'b0);
            3'd6: push({f7, rs2, rs1, f3, rd, 7'h53}, 1'b0);
            3'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    push({f7, imm[4:0], rs1, f3, rd, 7'h13}, !(s >= 0 && s <= 31));
                else
                    push({imm[11:0], rs1, f3, rd, 7'h13}, !in12);
            end
            3'd2: push({imm[11:0], rs1, f3, rd, 7'h03}, !in12);
            3'd3: push({imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23}, !in12);
            3'd4: push({imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63},
                       (s % 2 != 0) || !(s >= -4096 && s <= 4094));
            3'd5: begin
                sum = imm + 32'h800;
                hi  = sum[31:12];
                lo  = imm[11:0];
                if (in12) begin
                    push({lo, 5'd0, 3'd0, rd, 7'h13}, 1'b0);
                end else if (lo == 12'd0) begin
                    push({hi, rd, 7'h37}, 1'b0);
                end else begin
                    push({hi, rd, 7'h37}, 1'b0);
                    push({lo, rd, 3'd0, rd, 7'h13}, 1'b0);
                end
            end
            default: push(32'h0, 1'b1);
        endcase
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            mcount = '0;
            chk("rst_v_o", 32'(bus.v_o), 32'd0);
            chk("rst_count", 32'(bus.count_o), 32'd0);
        end else begin
            chk("yumi_legal", 32'(bus.yumi_i & !bus.v_o), 32'd0);
            chk("v_o", 32'(bus.v_o), 32'(q.size() != 0));
            chk("count_o", 32'(bus.count_o), 32'(mcount));
            chk("ready_o", 32'(bus.ready_o),
                32'((q.size() < 2) && (q.size() == 0 || bus.yumi_i)));
            if (bus.v_o && q.size() != 0) begin
                chk("instr_o", bus.instr_o, q[0].w);
                chk("err_o", 32'(bus.err_o), 32'(q[0].e));
                if (bus.yumi_i) begin
                    void'(q.pop_front());
                    mcount = mcount + 16'd1;
                end
            end
            if (bus.v_i && bus.ready_o)
                model_accept(bus.kind_i, bus.rd_i, bus.rs1_i, bus.rs2_i,
                             bus.funct3_i, bus.funct7_i, bus.imm_i);
        end
    end

    // Present a descriptor and hold it until the edge that accepts it.
    task automatic send(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int t;
        bus.kind_i   = kind;
        bus.rd_i     = rd;
        bus.rs1_i    = rs1;
        bus.rs2_i    = rs2;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
        bus.imm_i    = imm;
        bus.v_i      = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.ready_o && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: ready_o stuck at 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.v_i = 1'b0;
    endtask

    task automatic quiesce();
        int t;
        idle();
        t = 0;
        @(negedge clk);
        while (bus.v_o && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: v_o stuck at 1 expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    // Literal check of the word visible this cycle.
    task automatic lit(string name, logic [31:0] w, logic e);
        @(negedge clk);
        chk({name, "_instr"}, bus.instr_o, w);
        chk({name, "_err"}, 32'(bus.err_o), 32'(e));
    endtask

    initial begin
        int          r;
        logic [2:0]  k;
        logic [31:0] im;

        yumi_en      = 1'b1;
        bus.v_i      = 1'b0;
        bus.kind_i   = '0;
        bus.rd_i     = '0;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        bus.funct3_i = '0;
        bus.funct7_i = '0;
        bus.imm_i    = '0;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        #1;

        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        idle();
        lit("op_add", 32'h002081B3, 1'b0);

        @(posedge clk); #1;
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        idle();
        lit("beq8", 32'h00208463, 1'b0);

        @(posedge clk); #1;
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        idle();
        lit("beq_odd", 32'h00208163, 1'b1);

        @(posedge clk); #1;
        send(3'd1, 5'd3, 5'd1, 5'd0, 3'd1, 7'd0, 32'd40);
        idle();
        lit("slli_40", 32'h00809193, 1'b1);

        // two-word LI
        quiesce();
        send(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        idle();
        lit("li_lui", 32'h123462B7, 1'b0);
        chk("li_ready_low", 32'(bus.ready_o), 32'd0);
        lit("li_addi", 32'hFFF28293, 1'b0);
        chk("li_ready_back", 32'(bus.ready_o), 32'd1);
        quiesce();
        chk("count_after_li", 32'(bus.count_o), 32'd6);

        send(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00010000);
        idle();
        lit("li_lui_only", 32'h000102B7, 1'b0);
        @(posedge clk); #1;
        send(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFB);
        idle();
        lit("li_addi_only", 32'hFFB00293, 1'b0);
        quiesce();
        chk("count_single_li", 32'(bus.count_o), 32'd8);

        // backpressure during the LI pair
        yumi_en = 1'b0;
        send(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        idle();
        repeat (3) begin
            lit("bp_hold", 32'h123462B7, 1'b0);
            chk("bp_ready", 32'(bus.ready_o), 32'd0);
            chk("bp_v_o", 32'(bus.v_o), 32'd1);
        end
        @(posedge clk); #1;
        yumi_en = 1'b1;
        lit("bp_release", 32'h123462B7, 1'b0);
        lit("bp_second", 32'hFFF28293, 1'b0);
        quiesce();
        chk("count_after_bp", 32'(bus.count_o), 32'd10);

        // reset while the ADDI half is latched
        yumi_en = 1'b0;
        send(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_v_o", 32'(bus.v_o), 32'd0);
        chk("midrst_count", 32'(bus.count_o), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        yumi_en = 1'b1;
        @(negedge clk);
        chk("postrst_ready", 32'(bus.ready_o), 32'd1);
        chk("postrst_v_o", 32'(bus.v_o), 32'd0);
        @(negedge clk);
        chk("postrst_no_addi", 32'(bus.v_o), 32'd0);
        @(posedge clk); #1;

        // back-to-back random OP/LOAD/STORE
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 2);
            k = (r == 0) ? 3'd0 : (r == 1) ? 3'd2 : 3'd3;
            r = int'($urandom_range(0, 4095)) - 2048;
            im = 32'(r);
            send(k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), im);
        end
        quiesce();
        chk("count_b2b", 32'(bus.count_o), 32'd20);

        // count wrap
        for (int i = 0; i < 65515; i++)
            send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        quiesce();
        chk("count_ffff", 32'(bus.count_o), 32'h0000FFFF);
        send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        quiesce();
        chk("count_wrap", 32'(bus.count_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
